// File: rtl/ddr_rx_crc5.sv
// HDR-DDR read-path CRC-5: buffers received bytes and runs a bit-serial CRC per frame.
// Optional received-CRC comparison is enabled with `define DDR_RX_CRC5_CHECK_EN.
module ddr_rx_crc5 #(
  parameter logic [4:0] POLY      = 5'b00101,
  parameter logic [4:0] SEED      = 5'b11111,
  parameter int         BUF_DEPTH = 2
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_rx_crc_en,
  input  logic [7:0] i_rx_crc_data,
  input  logic       i_rx_crc_data_valid,
  input  logic       i_rx_crc_last,
  output logic [4:0] o_crc_value,
  output logic       o_crc_valid,
  output logic       o_crc_busy,
  output logic       o_crc_overflow,
`ifdef DDR_RX_CRC5_CHECK_EN
  input  logic [4:0] i_rx_crc_rcvd,
  input  logic       i_rx_crc_rcvd_valid,
  output logic       o_crc_error,
`endif
  output logic [1:0] o_dbg_state
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [8:0]      buf_mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            last_q;
  logic [4:0]      crc, crc_step;
  logic            frame_open;
  logic            buf_empty, buf_full, push_req, push, pop, drop, fb;

  // Handshake: a byte is offered when en and valid are both high in a cycle; it is
  // accepted if the buffer has room or an entry leaves in that same cycle.
  always_comb begin
    buf_empty = (count == '0);
    buf_full  = (count == CW'(BUF_DEPTH));
    pop       = (state == LOAD);
    push_req  = i_rx_crc_en & i_rx_crc_data_valid;
    push      = push_req & (~buf_full | pop);
    drop      = push_req & buf_full & ~pop;
    fb        = crc[4] ^ shreg[7];
    crc_step  = {crc[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!buf_empty) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        if (bit_cnt == 3'd7) begin
          if (last_q)          state_nxt = DONE;
          else if (!buf_empty) state_nxt = LOAD;
          else                 state_nxt = IDLE;
        end
      end
      DONE:  state_nxt = buf_empty ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (push) buf_mem[wr_ptr] <= {i_rx_crc_last, i_rx_crc_data};
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      last_q         <= 1'b0;
      crc            <= SEED;
      frame_open     <= 1'b0;
      o_crc_value    <= '0;
      o_crc_valid    <= 1'b0;
      o_crc_overflow <= 1'b0;
    end else if (!i_rx_crc_en) begin
      // Abort: drop everything in flight but keep the last reported CRC.
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      crc            <= SEED;
      frame_open     <= 1'b0;
      o_crc_valid    <= 1'b0;
      o_crc_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_crc_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (drop) o_crc_overflow <= 1'b1;
      case (state)
        LOAD: begin
          {last_q, shreg} <= buf_mem[rd_ptr];
          bit_cnt         <= '0;
          if (!frame_open) begin
            crc        <= SEED;
            frame_open <= 1'b1;
          end
        end
        SHIFT: begin
          crc     <= crc_step;
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          // Result and pulse land together so the DONE cycle presents a coherent value.
          if (bit_cnt == 3'd7 && last_q) begin
            o_crc_value <= crc_step;
            o_crc_valid <= 1'b1;
          end
        end
        DONE: frame_open <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_crc_busy  = ~buf_empty | (state != IDLE);
  assign o_dbg_state = state;

`ifdef DDR_RX_CRC5_CHECK_EN
  logic       rcvd_pend, done_pend, have_rcvd, have_done;
  logic [4:0] rcvd_q, rcvd_cmp;

  // Compare once both the computed and the received CRC of a frame are known.
  always_comb begin
    have_rcvd = rcvd_pend | i_rx_crc_rcvd_valid;
    have_done = done_pend | o_crc_valid;
    rcvd_cmp  = i_rx_crc_rcvd_valid ? i_rx_crc_rcvd : rcvd_q;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst || !i_rx_crc_en) begin
      rcvd_pend   <= 1'b0;
      done_pend   <= 1'b0;
      rcvd_q      <= '0;
      o_crc_error <= 1'b0;
    end else begin
      o_crc_error <= 1'b0;
      if (have_rcvd && have_done) begin
        o_crc_error <= (rcvd_cmp != o_crc_value);
        rcvd_pend   <= 1'b0;
        done_pend   <= 1'b0;
      end else begin
        if (i_rx_crc_rcvd_valid) begin
          rcvd_pend <= 1'b1;
          rcvd_q    <= i_rx_crc_rcvd;
        end
        if (o_crc_valid) done_pend <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddr_rx_crc5.sv
// Self-checking bench for ddr_rx_crc5: directed cases plus random frames against a
// polynomial-division CRC model with an expected-result queue.
module tb_ddr_rx_crc5;

  localparam logic [4:0] SEED = 5'h1F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dv = 1'b0;
  logic       last = 1'b0;
  logic [7:0] data = '0;
  logic [4:0] crc_value;
  logic       crc_valid, busy, ovf;
  logic [1:0] dbg_state;
`ifdef DDR_RX_CRC5_CHECK_EN
  logic [4:0] rcvd = '0;
  logic       rcvd_valid = 1'b0;
  logic       crc_error;
  int         err_pulses = 0;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [4:0] model_val = '0;
  logic [4:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] frame_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_rx_crc5 dut (
    .i_sys_clk           (clk),
    .i_sys_rst           (rst),
    .i_rx_crc_en         (en),
    .i_rx_crc_data       (data),
    .i_rx_crc_data_valid (dv),
    .i_rx_crc_last       (last),
    .o_crc_value         (crc_value),
    .o_crc_valid         (crc_valid),
    .o_crc_busy          (busy),
    .o_crc_overflow      (ovf),
`ifdef DDR_RX_CRC5_CHECK_EN
    .i_rx_crc_rcvd       (rcvd),
    .i_rx_crc_rcvd_valid (rcvd_valid),
    .o_crc_error         (crc_error),
`endif
    .o_dbg_state         (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: remainder of (M(x)*x^5 + SEED*x^len) mod (x^5+x^2+1).
  function automatic logic [4:0] ref_crc(input logic [7:0] bytes[$]);
    logic [63:0] v;
    int nbits;
    v = '0;
    nbits = bytes.size() * 8;
    foreach (bytes[i]) v = (v << 8) | 64'(bytes[i]);
    v = (v << 5) ^ (64'(SEED) << nbits);
    for (int i = 63; i >= 5; i--)
      if (v[i]) v = v ^ (64'h25 << (i - 5));
    return v[4:0];
  endfunction

  // driver tasks
  task automatic drive_byte(input logic [7:0] d, input logic l, input bit keep, input bit timed);
    data = d;
    last = l;
    dv   = 1'b1;
    if (keep) begin
      frame_q.push_back(d);
      if (l) begin
        exp_q.push_back(ref_crc(frame_q));
        exp_cyc_q.push_back(timed ? cyc + 11 : -1);
        frame_q.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    drive_byte(d, l, 1'b1, 1'b1);
    dv   = 1'b0;
    last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    int k;
    k = 0;
    while (!crc_valid && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!crc_valid) check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_cyc_q.delete();
    frame_q.delete();
  endtask

  // scoreboard
  always @(negedge clk) begin
    int t;
    if (!rst && crc_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        model_val = exp_q.pop_front();
        t = exp_cyc_q.pop_front();
        check_eq("crc_value", 32'(crc_value), 32'(model_val));
        if (t >= 0) check_eq("valid_latency", cyc, t);
      end
    end
  end

`ifdef DDR_RX_CRC5_CHECK_EN
  always @(negedge clk) if (crc_error) err_pulses++;
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: cycle %0d reached", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    idle(3);
    check_eq("rst_value", 32'(crc_value), 32'd0);
    check_eq("rst_valid", 32'(crc_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overflow", 32'(ovf), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    idle(1);

    // single zero byte: 0x0F, 10-cycle latency, busy drops afterwards
    send_byte(8'h00, 1'b1);
    wait_valid(20);
    check_eq("t1_value", 32'(crc_value), 32'h0F);
    idle(1);
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    idle(5);

    // two-byte frame, 16 clocks apart
    send_byte(8'h00, 1'b0);
    idle(15);
    send_byte(8'h00, 1'b1);
    wait_valid(20);
    check_eq("t2_value", 32'(crc_value), 32'h01);
    idle(1);
    check_eq("t2_overflow", 32'(ovf), 32'd0);
    idle(5);

    // back-to-back burst: three accepted, fourth dropped
    drive_byte(8'hA5, 1'b0, 1'b1, 1'b0);
    drive_byte(8'h3C, 1'b0, 1'b1, 1'b0);
    drive_byte(8'h5A, 1'b1, 1'b1, 1'b0);
    check_eq("t3_no_overflow_yet", 32'(ovf), 32'd0);
    drive_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    dv   = 1'b0;
    last = 1'b0;
    check_eq("t3_overflow_set", 32'(ovf), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd1);
    wait_valid(60);
    idle(3);
    check_eq("t3_overflow_sticky", 32'(ovf), 32'd1);
    en = 1'b0;
    clear_model();
    idle(1);
    en = 1'b1;
    check_eq("t3_overflow_cleared", 32'(ovf), 32'd0);
    check_eq("t3_busy_cleared", 32'(busy), 32'd0);
    idle(3);

    // abort mid-frame: no pulse, value held, seed restored afterwards
    send_byte(8'h00, 1'b1);
    idle(4);
    en = 1'b0;
    clear_model();
    idle(1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_value_held", 32'(crc_value), 32'(model_val));
    en = 1'b1;
    idle(20);
    send_byte(8'h00, 1'b1);
    wait_valid(20);
    check_eq("t4_reseed_value", 32'(crc_value), 32'h0F);
    idle(3);

    // reset mid-SHIFT
    send_byte(8'h81, 1'b1);
    idle(4);
    rst = 1'b1;
    clear_model();
    idle(1);
    check_eq("t5_rst_value", 32'(crc_value), 32'd0);
    check_eq("t5_rst_valid", 32'(crc_valid), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_overflow", 32'(ovf), 32'd0);
    model_val = '0;
    rst = 1'b0;
    idle(1);
    send_byte(8'h00, 1'b1);
    wait_valid(20);
    check_eq("t5_after_value", 32'(crc_value), 32'h0F);
    idle(3);

    // random frames of 1..4 bytes at normal RX spacing
    for (int f = 0; f < 25; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        send_byte(8'($urandom), (b == nb - 1));
        idle($urandom_range(15, 19));
      end
    end
    idle(20);
    check_eq("random_no_overflow", 32'(ovf), 32'd0);

`ifdef DDR_RX_CRC5_CHECK_EN
    err_pulses = 0;
    rcvd = 5'h0F;
    send_byte(8'h00, 1'b1);
    rcvd_valid = 1'b1;
    idle(1);
    rcvd_valid = 1'b0;
    wait_valid(20);
    idle(4);
    check_eq("chk_match_no_error", err_pulses, 32'd0);
    rcvd = 5'h10;
    send_byte(8'h00, 1'b1);
    rcvd_valid = 1'b1;
    idle(1);
    rcvd_valid = 1'b0;
    wait_valid(20);
    idle(4);
    check_eq("chk_mismatch_error", err_pulses, 32'd1);
`endif

    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
